// File: rtl/snes_pad_responder.sv
// SNES controller responder: answers console latch/clock strobes by
// shifting the 12 button bits (plus 4 idle bits) out on pad_data.
module snes_pad_responder #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 21477
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] buttons,
  input  logic        pad_latch,
  input  logic        pad_clk,
  output logic        pad_data,
  output logic        busy,
  output logic [4:0]  bit_cnt,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT,
    DONE
  } state_e;

  logic [SYNC_STAGES-1:0] lat_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   lat_prev_q;
  logic                   clk_prev_q;
  logic                   lat_s;
  logic                   clk_s;
  logic                   lat_fall;
  logic                   clk_rise;

  state_e          state_q;
  logic [15:0]     shift_q;
  logic [4:0]      bit_cnt_q;
  logic            frame_done_q;
  logic [7:0]      frame_count_q;
  logic [TW-1:0]   timer_q;
  logic            pad_data_q;
  logic            pad_data_d;

  // Synchronizers reset to the bus idle levels so no edge is seen at release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_sync_q <= '0;
      clk_sync_q <= '1;
      lat_prev_q <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], pad_latch};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
      lat_prev_q <= lat_sync_q[SYNC_STAGES-1];
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign lat_s    = lat_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign lat_fall = ~lat_s & lat_prev_q;
  assign clk_rise = clk_s & ~clk_prev_q;

  always_comb begin
    pad_data_d = 1'b1;
    unique case (state_q)
      IDLE:  pad_data_d = 1'b1;
      LATCH: pad_data_d = ~shift_q[0];
      SHIFT: pad_data_d = ~shift_q[0];
      DONE:  pad_data_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= 16'hFFFF;
      bit_cnt_q     <= 5'd0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      timer_q       <= '0;
      pad_data_q    <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;
      pad_data_q   <= pad_data_d;
      if (lat_s) begin
        state_q   <= LATCH;
        shift_q   <= {4'b0000, buttons};
        bit_cnt_q <= 5'd0;
      end else begin
        unique case (state_q)
          IDLE: ;
          LATCH: begin
            // Clock edges in this cycle are dropped: latch wins
            if (lat_fall) begin
              state_q <= SHIFT;
              timer_q <= '0;
            end
          end
          SHIFT: begin
            if (clk_rise) begin
              shift_q   <= {1'b1, shift_q[15:1]};
              bit_cnt_q <= bit_cnt_q + 5'd1;
              timer_q   <= '0;
              if (bit_cnt_q == 5'd15) begin
                state_q       <= DONE;
                frame_done_q  <= 1'b1;
                frame_count_q <= frame_count_q + 8'd1;
              end
            end else if (timer_q == TLAST) begin
              state_q   <= IDLE;
              shift_q   <= 16'hFFFF;
              bit_cnt_q <= 5'd0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          DONE: begin
            if (clk_rise) begin
              timer_q <= '0;
            end else if (timer_q == TLAST) begin
              state_q   <= IDLE;
              shift_q   <= 16'hFFFF;
              bit_cnt_q <= 5'd0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign pad_data    = pad_data_q;
  assign busy        = (state_q != IDLE);
  assign bit_cnt     = bit_cnt_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder with a queue of expected
// serial bits built from the driven buttons word.
module tb_snes_pad_responder;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] buttons = 12'h000;
  logic        pad_latch = 1'b0;
  logic        pad_clk = 1'b1;
  logic        pad_data;
  logic        busy;
  logic [4:0]  bit_cnt;
  logic        frame_done;
  logic [7:0]  frame_count;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int fd_base;
  logic exp_q[$];
  logic exp_bit;

  snes_pad_responder #(
    .SYNC_STAGES (2),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .pad_data   (pad_data),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic latch_pulse(input logic [11:0] b);
    buttons   = b;
    pad_latch = 1'b1;
    tick(12);
    pad_latch = 1'b0;
    tick(8);
  endtask

  task automatic clk_pulse();
    pad_clk = 1'b0;
    tick(6);
    pad_clk = 1'b1;
    tick(6);
  endtask

  task automatic run_frame(input logic [11:0] b, input bit chk);
    logic [15:0] word;
    word = {4'b0000, b};
    latch_pulse(b);
    buttons = ~b;
    exp_q.push_back(~word[0]);
    exp_bit = exp_q.pop_front();
    if (chk) check("bit0", {15'd0, pad_data}, {15'd0, exp_bit});
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back(k < 16 ? ~word[k] : 1'b0);
      clk_pulse();
      exp_bit = exp_q.pop_front();
      if (chk) check($sformatf("bit%0d", k), {15'd0, pad_data},
                     {15'd0, exp_bit});
    end
  endtask

  initial begin
    int fc;
    tick(1);
    check("rst_pad_data", {15'd0, pad_data}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_bit_cnt", {11'd0, bit_cnt}, 16'd0);
    check("rst_frame_done", {15'd0, frame_done}, 16'd0);
    check("rst_frame_count", {8'd0, frame_count}, 16'd0);
    reset = 1'b0;
    tick(10);
    check("post_rst_busy", {15'd0, busy}, 16'd0);
    check("post_rst_pad_data", {15'd0, pad_data}, 16'd1);

    clk_pulse();
    check("idle_clk_bit_cnt", {11'd0, bit_cnt}, 16'd0);

    fd_base = fd_cnt;
    run_frame(12'h001, 1'b1);
    check("f1_frame_done_pulses", 16'(fd_cnt - fd_base), 16'd1);
    check("f1_frame_count", {8'd0, frame_count}, 16'd1);
    check("f1_busy_done", {15'd0, busy}, 16'd1);

    fd_base = fd_cnt;
    run_frame(12'hFFF, 1'b1);
    check("f2_bit_cnt", {11'd0, bit_cnt}, 16'd16);
    clk_pulse();
    check("done_sat_bit_cnt", {11'd0, bit_cnt}, 16'd16);
    check("done_pad_data", {15'd0, pad_data}, 16'd0);
    check("f2_frame_done_pulses", 16'(fd_cnt - fd_base), 16'd1);
    tick(TO + 10);
    check("done_timeout_busy", {15'd0, busy}, 16'd0);
    check("done_timeout_pad", {15'd0, pad_data}, 16'd1);

    fc = frame_count;
    fd_base = fd_cnt;
    latch_pulse(12'h555);
    repeat (5) clk_pulse();
    check("to_mid_bit_cnt", {11'd0, bit_cnt}, 16'd5);
    tick(TO + 10);
    check("to_busy", {15'd0, busy}, 16'd0);
    check("to_pad_data", {15'd0, pad_data}, 16'd1);
    check("to_bit_cnt", {11'd0, bit_cnt}, 16'd0);
    check("to_frame_count", {8'd0, frame_count}, 16'(fc));
    check("to_no_frame_done", 16'(fd_cnt - fd_base), 16'd0);

    latch_pulse(12'h0A4);
    repeat (8) clk_pulse();
    check("ab_mid_bit_cnt", {11'd0, bit_cnt}, 16'd8);
    latch_pulse(12'h35B);
    check("ab_bit_cnt", {11'd0, bit_cnt}, 16'd0);
    check("ab_pad_data0", {15'd0, pad_data}, 16'd0);
    clk_pulse();
    check("ab_pad_data1", {15'd0, pad_data}, 16'd0);
    clk_pulse();
    check("ab_pad_data2", {15'd0, pad_data}, 16'd1);
    check("ab_frame_count", {8'd0, frame_count}, 16'(fc));
    check("ab_no_frame_done", 16'(fd_cnt - fd_base), 16'd0);

    buttons   = 12'h801;
    pad_latch = 1'b1;
    pad_clk   = 1'b0;
    tick(12);
    pad_latch = 1'b0;
    pad_clk   = 1'b1;
    tick(8);
    check("tie_busy", {15'd0, busy}, 16'd1);
    check("tie_bit_cnt", {11'd0, bit_cnt}, 16'd0);
    check("tie_pad_data", {15'd0, pad_data}, 16'd0);
    clk_pulse();
    check("tie_next_bit_cnt", {11'd0, bit_cnt}, 16'd1);
    check("tie_next_pad", {15'd0, pad_data}, 16'd1);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    fd_base = fd_cnt;
    for (int i = 0; i < 256; i++) begin
      run_frame(12'(i * 37), 1'b0);
      if (i == 254) check("wrap_255", {8'd0, frame_count}, 16'd255);
    end
    check("wrap_0", {8'd0, frame_count}, 16'd0);
    check("wrap_pulses", 16'(fd_cnt - fd_base), 16'd256);

    fd_base = fd_cnt;
    latch_pulse(12'h3C3);
    repeat (5) clk_pulse();
    check("f257_busy", {15'd0, busy}, 16'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_pad_data", {15'd0, pad_data}, 16'd1);
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_bit_cnt", {11'd0, bit_cnt}, 16'd0);
    check("arst_frame_done", {15'd0, frame_done}, 16'd0);
    check("arst_frame_count", {8'd0, frame_count}, 16'd0);
    tick(3);
    reset = 1'b0;
    tick(4);
    check("arst_no_pulse", 16'(fd_cnt - fd_base), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
